fp_norm_round: RTL and testbench

- Post-multiply stage for the single-precision FP multiplier.
- Consumes the 48-bit mantissa product from the shift-add multiplier datapath, plus the sign, exponent sum and special-case flags produced by the unpack logic.
- Normalizes the product, rounds it to nearest-even, checks exponent range and packs an IEEE-754 single result.
- Multi-cycle FSM with fixed latency and a start/done handshake.

---
 rtl/fp_norm_round.sv | 164 ++++++++++++++++
 tb/tb_fp_norm_round.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/fp_norm_round.sv
// Post-multiply normalize / round-to-nearest-even / range-check / pack stage
// of the single-precision multiplier.  Fixed four-state pass per operand.
module fp_norm_round #(
   parameter int          EXP_W = 10,
   parameter logic [31:0] QNAN  = 32'h7FC00000
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    start,
   input  logic [47:0]             p,
   input  logic                    sign,
   input  logic signed [EXP_W-1:0] exp_sum,
   input  logic                    in_nan,
   input  logic                    in_inf,
   input  logic                    in_zero,
   output logic                    busy,
   output logic                    done,
   output logic [31:0]             result,
   output logic                    overflow,
   output logic                    underflow
);

   // Handshake: start is sampled only while IDLE (ignored otherwise, never
   // queued); done pulses for one cycle with result/overflow/underflow valid,
   // and those outputs hold until the next completed operation or reset.
   typedef enum logic [1:0] {IDLE, NORM, ROUND, FINAL} state_t;

   localparam logic signed [EXP_W-1:0] E_MAX  = EXP_W'(255);
   localparam logic signed [EXP_W-1:0] E_ZERO = '0;
   localparam logic signed [EXP_W-1:0] E_ONE  = EXP_W'(1);

   state_t state, state_nxt;

   // Captured operands
   logic [47:0]             p_q;
   logic                    sign_q;
   logic signed [EXP_W-1:0] exp_q;
   logic                    nan_q, inf_q, zero_q;

   // Working mantissa, guard, sticky and exponent
   logic [23:0]             m_q;
   logic                    g_q, s_q;
   logic signed [EXP_W-1:0] e_q;

   // Combinational stage results
   logic [23:0]             norm_m;
   logic                    norm_g, norm_s;
   logic signed [EXP_W-1:0] norm_e;
   logic                    round_inc;
   logic [24:0]             round_sum;
   logic [31:0]             pack_result;
   logic                    pack_ovf, pack_udf;

   always_ff @(posedge clk) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = NORM;
         NORM:    state_nxt = ROUND;
         ROUND:   state_nxt = FINAL;
         FINAL:   state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   assign busy = (state != IDLE);

   // Product lies in [1,4): bit 47 set means the binary point moves one place.
   always_comb begin
      if (p_q[47]) begin
         norm_m = p_q[47:24];
         norm_g = p_q[23];
         norm_s = |p_q[22:0];
         norm_e = exp_q + E_ONE;
      end else begin
         norm_m = p_q[46:23];
         norm_g = p_q[22];
         norm_s = |p_q[21:0];
         norm_e = exp_q;
      end
   end

   assign round_inc = g_q & (s_q | m_q[0]);
   assign round_sum = {1'b0, m_q} + {24'd0, round_inc};

   // Specials take priority over range checks; denormal results flush to zero.
   always_comb begin
      pack_result = {sign_q, e_q[7:0], m_q[22:0]};
      pack_ovf    = 1'b0;
      pack_udf    = 1'b0;
      if (nan_q) begin
         pack_result = QNAN;
      end else if (inf_q) begin
         pack_result = {sign_q, 8'hFF, 23'd0};
      end else if (zero_q) begin
         pack_result = {sign_q, 31'd0};
      end else if (e_q >= E_MAX) begin
         pack_result = {sign_q, 8'hFF, 23'd0};
         pack_ovf    = 1'b1;
      end else if (e_q <= E_ZERO) begin
         pack_result = {sign_q, 31'd0};
         pack_udf    = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         p_q       <= '0;
         sign_q    <= 1'b0;
         exp_q     <= '0;
         nan_q     <= 1'b0;
         inf_q     <= 1'b0;
         zero_q    <= 1'b0;
         m_q       <= '0;
         g_q       <= 1'b0;
         s_q       <= 1'b0;
         e_q       <= '0;
         done      <= 1'b0;
         result    <= '0;
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  p_q    <= p;
                  sign_q <= sign;
                  exp_q  <= exp_sum;
                  nan_q  <= in_nan;
                  inf_q  <= in_inf;
                  zero_q <= in_zero;
               end
            end
            NORM: begin
               m_q <= norm_m;
               g_q <= norm_g;
               s_q <= norm_s;
               e_q <= norm_e;
            end
            ROUND: begin
               if (round_sum[24]) begin
                  m_q <= 24'h800000;
                  e_q <= e_q + E_ONE;
               end else begin
                  m_q <= round_sum[23:0];
               end
            end
            FINAL: begin
               result    <= pack_result;
               overflow  <= pack_ovf;
               underflow <= pack_udf;
               done      <= 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_fp_norm_round.sv
// Scoreboard bench for fp_norm_round: directed test-plan vectors plus random
// mantissa products, checked against an integer-arithmetic rounding model.
module tb_fp_norm_round;

   localparam int EXP_W = 10;
   localparam logic [31:0] QNAN = 32'h7FC00000;

   logic                    clk = 1'b0;
   logic                    rst_n = 1'b0;
   logic                    start = 1'b0;
   logic [47:0]             p = '0;
   logic                    sign = 1'b0;
   logic signed [EXP_W-1:0] exp_sum = '0;
   logic                    in_nan = 1'b0, in_inf = 1'b0, in_zero = 1'b0;
   logic                    busy, done, overflow, underflow;
   logic [31:0]             result;

   logic [33:0] exp_q[$];
   int          exp_cyc_q[$];
   int          cyc = 0;
   int          n_vec = 0;
   int          n_checks = 0;
   int          miscompares = 0;

   fp_norm_round #(.EXP_W(EXP_W), .QNAN(QNAN)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .p(p), .sign(sign),
      .exp_sum(exp_sum), .in_nan(in_nan), .in_inf(in_inf), .in_zero(in_zero),
      .busy(busy), .done(done), .result(result),
      .overflow(overflow), .underflow(underflow)
   );

   // ---------------- clock / cycle counter ----------------
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- reference model ----------------
   // Returns {overflow, underflow, result}.
   function automatic logic [33:0] model(logic [47:0] pv, logic sv, int es,
                                         logic nan, logic inf, logic zero);
      longint unsigned q, rem, half, full;
      int sh, e;
      if (nan)  return {2'b00, QNAN};
      if (inf)  return {2'b00, sv, 8'hFF, 23'd0};
      if (zero) return {2'b00, sv, 31'd0};
      full = 64'(pv);
      sh = (full >= 64'h8000_0000_0000) ? 24 : 23;
      e  = es + ((sh == 24) ? 1 : 0);
      q    = full >> sh;
      rem  = full - (q << sh);
      half = 64'd1 << (sh - 1);
      if (rem > half || (rem == half && (q % 2) == 1)) q = q + 1;
      if (q == (64'd1 << 24)) begin
         q = 64'd1 << 23;
         e = e + 1;
      end
      if (e >= 255) return {2'b10, sv, 8'hFF, 23'd0};
      if (e <= 0)   return {2'b01, sv, 31'd0};
      return {2'b00, sv, e[7:0], q[22:0]};
   endfunction

   task automatic check(string name, logic [63:0] act, logic [63:0] expv);
      n_checks++;
      if (act !== expv) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
      end
   endtask

   // ---------------- driver ----------------
   // Drives one start pulse from the current negedge.
   task automatic issue_now(logic [47:0] pv, logic sv, int es,
                            logic nan, logic inf, logic zero);
      p = pv; sign = sv; exp_sum = EXP_W'(es);
      in_nan = nan; in_inf = inf; in_zero = zero;
      start = 1'b1;
      exp_q.push_back(model(pv, sv, es, nan, inf, zero));
      exp_cyc_q.push_back(cyc + 4);
      n_vec++;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic issue(logic [47:0] pv, logic sv, int es,
                        logic nan, logic inf, logic zero);
      @(negedge clk);
      issue_now(pv, sv, es, nan, inf, zero);
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 40) begin
         @(negedge clk);
         n++;
      end
      if (exp_q.size() != 0) begin
         check("drain_timeout", 64'(exp_q.size()), 64'd0);
         exp_q.delete();
         exp_cyc_q.delete();
      end
   endtask

   // ---------------- monitor / scoreboard ----------------
   always @(negedge clk) begin
      if (rst_n && done) begin
         if (exp_q.size() == 0) begin
            check("unexpected_done", 64'd1, 64'd0);
         end else begin
            logic [33:0] e;
            int ec;
            e  = exp_q.pop_front();
            ec = exp_cyc_q.pop_front();
            check("result", 64'(result), 64'(e[31:0]));
            check("flags", 64'({overflow, underflow}), 64'(e[33:32]));
            check("latency", 64'(cyc), 64'(ec));
         end
      end
   end

   // ---------------- stimulus ----------------
   initial begin
      logic [47:0] a, b;
      int es, sel;
      bit seen;

      repeat (3) @(negedge clk);
      check("reset_busy", 64'(busy), 64'd0);
      check("reset_done", 64'(done), 64'd0);
      check("reset_result", 64'(result), 64'd0);
      check("reset_flags", 64'({overflow, underflow}), 64'd0);
      rst_n = 1'b1;

      // Directed test-plan vectors
      issue(48'h900000000000, 1'b0, 127, 0, 0, 0); drain();
      issue(48'h400000400000, 1'b0, 127, 0, 0, 0); drain();
      issue(48'h400000C00000, 1'b0, 127, 0, 0, 0); drain();
      issue(48'h7FFFFFC00000, 1'b1, 127, 0, 0, 0); drain();
      issue(48'h900000000000, 1'b0, 254, 0, 0, 0); drain();
      issue(48'h400000000000, 1'b1, -1,  0, 0, 0); drain();
      issue(48'h400000000000, 1'b0, 127, 1, 1, 0); drain();
      issue(48'h400000000000, 1'b1, 127, 0, 1, 0); drain();
      issue(48'h400000000000, 1'b0, 127, 0, 0, 1); drain();
      issue(48'h900000000000, 1'b0, 1,   0, 0, 0); drain();
      issue(48'h400000000000, 1'b0, 254, 0, 0, 0); drain();

      // start pulses during NORM and ROUND must be ignored
      issue(48'h900000000000, 1'b0, 127, 0, 0, 0);
      in_nan = 1'b1; start = 1'b1;
      check("busy_norm", 64'(busy), 64'd1);
      @(negedge clk);
      @(negedge clk);
      start = 1'b0; in_nan = 1'b0;
      drain();
      repeat (6) @(negedge clk);

      // reset during ROUND discards the operation
      issue(48'h600000000000, 1'b1, 130, 0, 0, 0);
      @(negedge clk);
      rst_n = 1'b0;
      exp_q.delete();
      exp_cyc_q.delete();
      @(negedge clk);
      check("rst_mid_busy", 64'(busy), 64'd0);
      check("rst_mid_done", 64'(done), 64'd0);
      check("rst_mid_result", 64'(result), 64'd0);
      rst_n = 1'b1;
      repeat (6) @(negedge clk);

      // back-to-back: new start in the cycle done is high
      issue(48'h900000000000, 1'b1, 100, 0, 0, 0);
      seen = 1'b0;
      for (int i = 0; i < 10 && !seen; i++) begin
         @(negedge clk);
         if (done) seen = 1'b1;
      end
      check("b2b_first_done", 64'(seen), 64'd1);
      issue_now(48'h5A5A5A5A5A5A, 1'b0, 50, 0, 0, 0);
      drain();

      // Randomized products of hidden-bit mantissas
      for (int i = 0; i < 200; i++) begin
         a = 48'(24'h800000 | $urandom_range(0, 24'h7FFFFF));
         b = 48'(24'h800000 | $urandom_range(0, 24'h7FFFFF));
         sel = $urandom_range(0, 15);
         es = $urandom_range(0, 506) - 125;
         if ($urandom_range(0, 3) == 0) a[22:0] = 23'h7FFFFF;
         if (sel == 0)      issue(a * b, 1'($urandom), es, 1, 1'($urandom), 1'($urandom));
         else if (sel == 1) issue(a * b, 1'($urandom), es, 0, 1, 0);
         else if (sel == 2) issue(a * b, 1'($urandom), es, 0, 0, 1);
         else               issue(a * b, 1'($urandom), es, 0, 0, 0);
         if ($urandom_range(0, 1) == 0) drain();
         else begin
            // start again as early as possible; done-cycle starts are legal
            seen = 1'b0;
            for (int k = 0; k < 10 && !seen; k++) begin
               @(negedge clk);
               if (done) seen = 1'b1;
            end
            check("rand_done_seen", 64'(seen), 64'd1);
            if (seen) issue_now(a * b, 1'b0, 127, 0, 0, 0);
            drain();
         end
      end

      repeat (4) @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, miscompares);
      $finish;
   end

endmodule
